// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: FSM states, load/store type
// bundles, data_size constants and the alignment check used by MEM_ADDR_ERR_EN.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } mem_state_t;

   localparam logic [1:0] STORE_SW  = 2'b00;
   localparam logic [1:0] STORE_SH  = 2'b01;
   localparam logic [1:0] STORE_SB  = 2'b10;
   localparam logic [1:0] STORE_RSV = 2'b11;

   // LoadType bundle: [6] LB, [5] LBU, [4] LH, [3] LHU, [2:0] word family
   // (bit 0 plain LW; bits 2:1 LWL/LWR, which are unaligned by design).
   localparam int unsigned LD_LB  = 6;
   localparam int unsigned LD_LBU = 5;
   localparam int unsigned LD_LH  = 4;
   localparam int unsigned LD_LHU = 3;
   localparam int unsigned LD_LW  = 0;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic addr_misaligned(
      input logic       mem_read,
      input logic       mem_write,
      input logic [6:0] load_type,
      input logic [1:0] store_type,
      input logic [1:0] addr_lo
   );
      logic word_acc;
      logic half_acc;
      word_acc = (mem_read && load_type[LD_LW]) ||
                 (mem_write && store_type == STORE_SW);
      half_acc = (mem_read && (load_type[LD_LH] || load_type[LD_LHU])) ||
                 (mem_write && store_type == STORE_SH);
      return (word_acc && addr_lo != 2'b00) || (half_acc && addr_lo[0]);
   endfunction

endpackage

// File: rtl/mem_stage_store_align.sv
// Store lane replication, byte-strobe and data_size generation for the data bus.
module mem_store_align
   import mem_stage_pkg::*;
(
   input  logic        is_store,
   input  logic [1:0]  store_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rt,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [1:0]  size
);

   always_comb begin
      wdata = '0;
      wstrb = '0;
      size  = SIZE_WORD;
      if (is_store) begin
         case (store_type)
            STORE_SW: begin
               wdata = rt;
               wstrb = '1;
            end
            STORE_SH: begin
               wdata = {2{rt[15:0]}};
               wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
               size  = SIZE_HALF;
            end
            STORE_SB: begin
               wdata = {4{rt[7:0]}};
               wstrb = 4'b0001 << addr_lo;
               size  = SIZE_BYTE;
            end
            default: begin
               // reserved encoding writes no bytes
               wdata = rt;
               wstrb = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stage register, single-outstanding data-bus FSM and
// writeback handoff. Define MEM_ADDR_ERR_EN to flag misaligned accesses (AdE_MEM_WB).
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        exe_to_mem_valid,
   output logic        mem_allowin,
   input  logic        wb_allowin,
   output logic        mem_to_wb_valid,
   input  logic        MemRead_EXE_MEM,
   input  logic        MemWrite_EXE_MEM,
   input  logic [6:0]  LoadType_EXE_MEM,
   input  logic [1:0]  StoreType_EXE_MEM,
   input  logic [31:0] ALUResult_EXE_MEM,
   input  logic [31:0] RegRdata2_EXE_MEM,
   input  logic [31:0] PC_EXE_MEM,
   input  logic [4:0]  RegWaddr_EXE_MEM,
   input  logic [3:0]  RegWrite_EXE_MEM,
   input  logic        MemToReg_EXE_MEM,
   input  logic        mfc0_EXE_MEM,
   input  logic [1:0]  MFHL_EXE_MEM,
   input  logic [31:0] HI_EXE_MEM,
   input  logic [31:0] LO_EXE_MEM,
   input  logic [31:0] cp0Rdata_EXE_MEM,
   output logic        MemRead_MEM_WB,
   output logic        MemWrite_MEM_WB,
   output logic [6:0]  LoadType_MEM_WB,
   output logic [1:0]  StoreType_MEM_WB,
   output logic [31:0] ALUResult_MEM_WB,
   output logic [31:0] RegRdata2_MEM_WB,
   output logic [31:0] PC_MEM_WB,
   output logic [4:0]  RegWaddr_MEM_WB,
   output logic [3:0]  RegWrite_MEM_WB,
   output logic        MemToReg_MEM_WB,
   output logic        mfc0_MEM_WB,
   output logic [1:0]  MFHL_MEM_WB,
   output logic [31:0] HI_MEM_WB,
   output logic [31:0] LO_MEM_WB,
   output logic [31:0] cp0Rdata_MEM_WB,
   output logic [31:0] MemRdata_MEM_WB,
`ifdef MEM_ADDR_ERR_EN
   output logic        AdE_MEM_WB,
`endif
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   mem_state_t state;
   logic       valid;
   logic       ready_go;
   logic       load_en;
   logic       start_exe;
   logic       addr_err_exe;
   logic       ade;
   logic       mem_busy;

`ifdef MEM_ADDR_ERR_EN
   assign addr_err_exe = addr_misaligned(MemRead_EXE_MEM, MemWrite_EXE_MEM,
                                         LoadType_EXE_MEM, StoreType_EXE_MEM,
                                         ALUResult_EXE_MEM[1:0]);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         AdE_MEM_WB <= 1'b0;
      else if (load_en)
         AdE_MEM_WB <= addr_err_exe;
   end

   assign ade = AdE_MEM_WB;
`else
   assign addr_err_exe = 1'b0;
   assign ade          = 1'b0;
`endif

   // Faulting or non-memory instructions never wait on the bus.
   assign mem_busy        = (MemRead_MEM_WB || MemWrite_MEM_WB) && !ade;
   assign ready_go        = !mem_busy || (state == S_DONE);
   assign mem_allowin     = !valid || (ready_go && wb_allowin);
   assign mem_to_wb_valid = valid && ready_go;
   assign load_en         = mem_allowin && exe_to_mem_valid;
   assign start_exe       = load_en && (MemRead_EXE_MEM || MemWrite_EXE_MEM) && !addr_err_exe;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid             <= 1'b0;
         MemRead_MEM_WB    <= 1'b0;
         MemWrite_MEM_WB   <= 1'b0;
         LoadType_MEM_WB   <= '0;
         StoreType_MEM_WB  <= '0;
         ALUResult_MEM_WB  <= '0;
         RegRdata2_MEM_WB  <= '0;
         PC_MEM_WB         <= '0;
         RegWaddr_MEM_WB   <= '0;
         RegWrite_MEM_WB   <= '0;
         MemToReg_MEM_WB   <= 1'b0;
         mfc0_MEM_WB       <= 1'b0;
         MFHL_MEM_WB       <= '0;
         HI_MEM_WB         <= '0;
         LO_MEM_WB         <= '0;
         cp0Rdata_MEM_WB   <= '0;
      end else begin
         if (mem_allowin)
            valid <= exe_to_mem_valid;
         if (load_en) begin
            MemRead_MEM_WB    <= MemRead_EXE_MEM;
            MemWrite_MEM_WB   <= MemWrite_EXE_MEM;
            LoadType_MEM_WB   <= LoadType_EXE_MEM;
            StoreType_MEM_WB  <= StoreType_EXE_MEM;
            ALUResult_MEM_WB  <= ALUResult_EXE_MEM;
            RegRdata2_MEM_WB  <= RegRdata2_EXE_MEM;
            PC_MEM_WB         <= PC_EXE_MEM;
            RegWaddr_MEM_WB   <= RegWaddr_EXE_MEM;
            RegWrite_MEM_WB   <= RegWrite_EXE_MEM;
            MemToReg_MEM_WB   <= MemToReg_EXE_MEM;
            mfc0_MEM_WB       <= mfc0_EXE_MEM;
            MFHL_MEM_WB       <= MFHL_EXE_MEM;
            HI_MEM_WB         <= HI_EXE_MEM;
            LO_MEM_WB         <= LO_EXE_MEM;
            cp0Rdata_MEM_WB   <= cp0Rdata_EXE_MEM;
         end
      end
   end

   // data_ok is only honoured once the request has been accepted, so stray
   // responses in IDLE/DONE (or after a reset) are dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= S_IDLE;
         data_req        <= 1'b0;
         MemRdata_MEM_WB <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_exe) begin
                  state    <= S_REQ;
                  data_req <= 1'b1;
               end
            end
            S_REQ: begin
               if (data_addr_ok) begin
                  data_req <= 1'b0;
                  if (data_data_ok) begin
                     MemRdata_MEM_WB <= data_rdata;
                     state           <= S_DONE;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (data_data_ok) begin
                  MemRdata_MEM_WB <= data_rdata;
                  state           <= S_DONE;
               end
            end
            S_DONE: begin
               if (valid && wb_allowin) begin
                  if (start_exe) begin
                     state    <= S_REQ;
                     data_req <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               data_req <= 1'b0;
            end
         endcase
      end
   end

   assign data_addr = {ALUResult_MEM_WB[31:2], 2'b00};
   assign data_wr   = MemWrite_MEM_WB;

   mem_store_align u_store_align (
      .is_store   (MemWrite_MEM_WB),
      .store_type (StoreType_MEM_WB),
      .addr_lo    (ALUResult_MEM_WB[1:0]),
      .rt         (RegRdata2_MEM_WB),
      .wdata      (data_wdata),
      .wstrb      (data_wstrb),
      .size       (data_size)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected retirements checked at
// the WB handshake, plus point checks of the data-bus request signals.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        exe_to_mem_valid;
   logic        mem_allowin;
   logic        wb_allowin;
   logic        mem_to_wb_valid;
   logic        MemRead_EXE_MEM, MemWrite_EXE_MEM;
   logic [6:0]  LoadType_EXE_MEM;
   logic [1:0]  StoreType_EXE_MEM;
   logic [31:0] ALUResult_EXE_MEM, RegRdata2_EXE_MEM, PC_EXE_MEM;
   logic [4:0]  RegWaddr_EXE_MEM;
   logic [3:0]  RegWrite_EXE_MEM;
   logic        MemToReg_EXE_MEM, mfc0_EXE_MEM;
   logic [1:0]  MFHL_EXE_MEM;
   logic [31:0] HI_EXE_MEM, LO_EXE_MEM, cp0Rdata_EXE_MEM;
   logic        MemRead_MEM_WB, MemWrite_MEM_WB;
   logic [6:0]  LoadType_MEM_WB;
   logic [1:0]  StoreType_MEM_WB;
   logic [31:0] ALUResult_MEM_WB, RegRdata2_MEM_WB, PC_MEM_WB;
   logic [4:0]  RegWaddr_MEM_WB;
   logic [3:0]  RegWrite_MEM_WB;
   logic        MemToReg_MEM_WB, mfc0_MEM_WB;
   logic [1:0]  MFHL_MEM_WB;
   logic [31:0] HI_MEM_WB, LO_MEM_WB, cp0Rdata_MEM_WB, MemRdata_MEM_WB;
`ifdef MEM_ADDR_ERR_EN
   logic        AdE_MEM_WB;
`endif
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] alu;
      logic [4:0]  waddr;
      logic        chk_rdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks, n_pass, n_fail;
   int   req_hs, req_cycles;
   int   hs0, cyc0;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .exe_to_mem_valid  (exe_to_mem_valid),
      .mem_allowin       (mem_allowin),
      .wb_allowin        (wb_allowin),
      .mem_to_wb_valid   (mem_to_wb_valid),
      .MemRead_EXE_MEM   (MemRead_EXE_MEM),
      .MemWrite_EXE_MEM  (MemWrite_EXE_MEM),
      .LoadType_EXE_MEM  (LoadType_EXE_MEM),
      .StoreType_EXE_MEM (StoreType_EXE_MEM),
      .ALUResult_EXE_MEM (ALUResult_EXE_MEM),
      .RegRdata2_EXE_MEM (RegRdata2_EXE_MEM),
      .PC_EXE_MEM        (PC_EXE_MEM),
      .RegWaddr_EXE_MEM  (RegWaddr_EXE_MEM),
      .RegWrite_EXE_MEM  (RegWrite_EXE_MEM),
      .MemToReg_EXE_MEM  (MemToReg_EXE_MEM),
      .mfc0_EXE_MEM      (mfc0_EXE_MEM),
      .MFHL_EXE_MEM      (MFHL_EXE_MEM),
      .HI_EXE_MEM        (HI_EXE_MEM),
      .LO_EXE_MEM        (LO_EXE_MEM),
      .cp0Rdata_EXE_MEM  (cp0Rdata_EXE_MEM),
      .MemRead_MEM_WB    (MemRead_MEM_WB),
      .MemWrite_MEM_WB   (MemWrite_MEM_WB),
      .LoadType_MEM_WB   (LoadType_MEM_WB),
      .StoreType_MEM_WB  (StoreType_MEM_WB),
      .ALUResult_MEM_WB  (ALUResult_MEM_WB),
      .RegRdata2_MEM_WB  (RegRdata2_MEM_WB),
      .PC_MEM_WB         (PC_MEM_WB),
      .RegWaddr_MEM_WB   (RegWaddr_MEM_WB),
      .RegWrite_MEM_WB   (RegWrite_MEM_WB),
      .MemToReg_MEM_WB   (MemToReg_MEM_WB),
      .mfc0_MEM_WB       (mfc0_MEM_WB),
      .MFHL_MEM_WB       (MFHL_MEM_WB),
      .HI_MEM_WB         (HI_MEM_WB),
      .LO_MEM_WB         (LO_MEM_WB),
      .cp0Rdata_MEM_WB   (cp0Rdata_MEM_WB),
      .MemRdata_MEM_WB   (MemRdata_MEM_WB),
`ifdef MEM_ADDR_ERR_EN
      .AdE_MEM_WB        (AdE_MEM_WB),
`endif
      .data_req          (data_req),
      .data_wr           (data_wr),
      .data_size         (data_size),
      .data_addr         (data_addr),
      .data_wdata        (data_wdata),
      .data_wstrb        (data_wstrb),
      .data_addr_ok      (data_addr_ok),
      .data_data_ok      (data_data_ok),
      .data_rdata        (data_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && mem_to_wb_valid && wb_allowin) begin
         if (sb_q.size() == 0) begin
            check("unexpected_retire_pc", PC_MEM_WB, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb_q.pop_front();
            check("wb_pc", PC_MEM_WB, mon_e.pc);
            check("wb_alu", ALUResult_MEM_WB, mon_e.alu);
            check("wb_waddr", 32'(RegWaddr_MEM_WB), 32'(mon_e.waddr));
            if (mon_e.chk_rdata)
               check("wb_rdata", MemRdata_MEM_WB, mon_e.rdata);
         end
      end
   end

   always @(posedge clk) begin
      if (resetn && data_req) begin
         req_cycles++;
         if (data_addr_ok)
            req_hs++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exe(input logic rd, input logic wr, input logic [6:0] lt,
                          input logic [1:0] st, input logic [31:0] alu,
                          input logic [31:0] rt, input logic [31:0] pc,
                          input logic [4:0] wa);
      MemRead_EXE_MEM   = rd;
      MemWrite_EXE_MEM  = wr;
      LoadType_EXE_MEM  = lt;
      StoreType_EXE_MEM = st;
      ALUResult_EXE_MEM = alu;
      RegRdata2_EXE_MEM = rt;
      PC_EXE_MEM        = pc;
      RegWaddr_EXE_MEM  = wa;
      RegWrite_EXE_MEM  = rd ? 4'hF : 4'h0;
      MemToReg_EXE_MEM  = rd;
      mfc0_EXE_MEM      = 1'b0;
      MFHL_EXE_MEM      = 2'b00;
      HI_EXE_MEM        = pc ^ 32'hA5A5_0000;
      LO_EXE_MEM        = pc ^ 32'h5A5A_0000;
      cp0Rdata_EXE_MEM  = 32'h0;
      exe_to_mem_valid  = 1'b1;
   endtask

   // Holds the instruction on the EXE side until MEM takes it, then drops valid.
   task automatic issue(input logic rd, input logic wr, input logic [6:0] lt,
                        input logic [1:0] st, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [31:0] pc,
                        input logic [4:0] wa);
      int waited;
      set_exe(rd, wr, lt, st, alu, rt, pc, wa);
      waited = 0;
      @(negedge clk);
      while (!mem_allowin && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!mem_allowin)
         check("issue_timeout_allowin", 32'(mem_allowin), 32'd1);
      @(posedge clk);
      #1;
      exe_to_mem_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_pass = 0; n_fail = 0;
      req_hs = 0; req_cycles = 0;
      resetn = 1'b0;
      wb_allowin = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata = '0;
      set_exe(1'b0, 1'b0, 7'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      exe_to_mem_valid = 1'b0;

      #3;
      check("rst_wb_valid", 32'(mem_to_wb_valid), 32'd0);
      check("rst_req", 32'(data_req), 32'd0);
      check("rst_allowin", 32'(mem_allowin), 32'd1);
      check("rst_rdata", MemRdata_MEM_WB, 32'd0);
      check("rst_pc", PC_MEM_WB, 32'd0);
      step(); step();
      resetn = 1'b1;
      step();

      // ALU op: one cycle through MEM, no bus activity
      wb_allowin = 1'b1;
      sb_q.push_back('{32'h400, 32'h1234, 5'd5, 1'b0, 32'h0});
      issue(1'b0, 1'b0, 7'd0, 2'd0, 32'h1234, 32'h0, 32'h400, 5'd5);
      @(negedge clk);
      check("add_wb_valid", 32'(mem_to_wb_valid), 32'd1);
      check("add_no_req", 32'(data_req), 32'd0);
      check("add_hi", HI_MEM_WB, 32'hA5A5_0400);
      step();

      // LW 0x100: addr_ok after two held cycles, data_ok three cycles later
      hs0 = req_hs; cyc0 = req_cycles;
      sb_q.push_back('{32'h404, 32'h100, 5'd8, 1'b1, 32'hDEAD_BEEF});
      issue(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h100, 32'h0, 32'h404, 5'd8);
      @(negedge clk);
      check("lw_req", 32'(data_req), 32'd1);
      check("lw_addr", data_addr, 32'h100);
      check("lw_size", 32'(data_size), 32'd2);
      check("lw_wstrb", 32'(data_wstrb), 32'd0);
      check("lw_wr", 32'(data_wr), 32'd0);
      check("lw_not_valid", 32'(mem_to_wb_valid), 32'd0);
      step();
      @(negedge clk);
      check("lw_req_hold", 32'(data_req), 32'd1);
      check("lw_addr_hold", data_addr, 32'h100);
      step();
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      @(negedge clk);
      check("lw_wait_noreq", 32'(data_req), 32'd0);
      check("lw_wait_not_valid", 32'(mem_to_wb_valid), 32'd0);
      step(); step();
      data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      step();
      data_data_ok = 1'b0; data_rdata = '0;
      @(negedge clk);
      check("lw_done_valid", 32'(mem_to_wb_valid), 32'd1);
      check("lw_single_req", 32'(req_hs - hs0), 32'd1);
      check("lw_req_cycles", 32'(req_cycles - cyc0), 32'd3);
      step();

      // SB 0x203: addr_ok and data_ok together
      sb_q.push_back('{32'h408, 32'h203, 5'd0, 1'b0, 32'h0});
      issue(1'b0, 1'b1, 7'd0, 2'b10, 32'h203, 32'h55, 32'h408, 5'd0);
      @(negedge clk);
      check("sb_addr", data_addr, 32'h200);
      check("sb_wstrb", 32'(data_wstrb), 32'h8);
      check("sb_wdata", data_wdata, 32'h5555_5555);
      check("sb_size", 32'(data_size), 32'd0);
      check("sb_wr", 32'(data_wr), 32'd1);
      data_addr_ok = 1'b1; data_data_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      check("sb_done_valid", 32'(mem_to_wb_valid), 32'd1);
      step();

      // SH 0x302: upper halfword lanes
      sb_q.push_back('{32'h40C, 32'h302, 5'd0, 1'b0, 32'h0});
      issue(1'b0, 1'b1, 7'd0, 2'b01, 32'h302, 32'h1234_ABCD, 32'h40C, 5'd0);
      @(negedge clk);
      check("sh_addr", data_addr, 32'h300);
      check("sh_wstrb", 32'(data_wstrb), 32'hC);
      check("sh_wdata", data_wdata, 32'hABCD_ABCD);
      check("sh_size", 32'(data_size), 32'd1);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b1;
      step();
      data_data_ok = 1'b0;
      @(negedge clk);
      check("sh_done_valid", 32'(mem_to_wb_valid), 32'd1);
      step();

      // SW 0x304
      sb_q.push_back('{32'h410, 32'h304, 5'd0, 1'b0, 32'h0});
      issue(1'b0, 1'b1, 7'd0, 2'b00, 32'h304, 32'h0BAD_F00D, 32'h410, 5'd0);
      @(negedge clk);
      check("sw_wstrb", 32'(data_wstrb), 32'hF);
      check("sw_wdata", data_wdata, 32'h0BAD_F00D);
      check("sw_size", 32'(data_size), 32'd2);
      data_addr_ok = 1'b1; data_data_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      step();

      // Load held in DONE by WB back-pressure, then back-to-back memory op
      wb_allowin = 1'b0;
      hs0 = req_hs;
      sb_q.push_back('{32'h414, 32'h500, 5'd9, 1'b1, 32'hCAFE_F00D});
      sb_q.push_back('{32'h418, 32'h600, 5'd10, 1'b1, 32'h1111_2222});
      issue(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h500, 32'h0, 32'h414, 5'd9);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      set_exe(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h600, 32'h0, 32'h418, 5'd10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(mem_to_wb_valid), 32'd1);
         check("stall_allowin", 32'(mem_allowin), 32'd0);
         check("stall_noreq", 32'(data_req), 32'd0);
         check("stall_rdata", MemRdata_MEM_WB, 32'hCAFE_F00D);
         step();
      end
      check("stall_single_req", 32'(req_hs - hs0), 32'd1);
      wb_allowin = 1'b1;
      step();
      exe_to_mem_valid = 1'b0;
      @(negedge clk);
      check("b2b_req", 32'(data_req), 32'd1);
      check("b2b_addr", data_addr, 32'h600);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      step();

      // Reset while waiting for data, then a stray data_ok
      issue(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h700, 32'h0, 32'h41C, 5'd11);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      check("rstw_valid", 32'(mem_to_wb_valid), 32'd0);
      check("rstw_req", 32'(data_req), 32'd0);
      check("rstw_rdata", MemRdata_MEM_WB, 32'd0);
      check("rstw_pc", PC_MEM_WB, 32'd0);
      check("rstw_allowin", 32'(mem_allowin), 32'd1);
      step();
      resetn = 1'b1;
      data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
      step();
      data_data_ok = 1'b0; data_rdata = '0;
      @(negedge clk);
      check("stray_rdata", MemRdata_MEM_WB, 32'd0);
      check("stray_valid", 32'(mem_to_wb_valid), 32'd0);
      check("stray_req", 32'(data_req), 32'd0);
      step();
      sb_q.push_back('{32'h420, 32'h720, 5'd12, 1'b1, 32'h7777_7777});
      issue(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h720, 32'h0, 32'h420, 5'd12);
      @(negedge clk);
      check("post_rst_req", 32'(data_req), 32'd1);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      step();

      // Misaligned LW 0x102
      cyc0 = req_cycles;
`ifdef MEM_ADDR_ERR_EN
      sb_q.push_back('{32'h424, 32'h102, 5'd13, 1'b0, 32'h0});
      issue(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h102, 32'h0, 32'h424, 5'd13);
      @(negedge clk);
      check("ade_flag", 32'(AdE_MEM_WB), 32'd1);
      check("ade_valid", 32'(mem_to_wb_valid), 32'd1);
      check("ade_noreq", 32'(data_req), 32'd0);
      step();
      check("ade_req_cycles", 32'(req_cycles - cyc0), 32'd0);
`else
      sb_q.push_back('{32'h424, 32'h102, 5'd13, 1'b1, 32'h1357_2468});
      issue(1'b1, 1'b0, 7'b0000001, 2'd0, 32'h102, 32'h0, 32'h424, 5'd13);
      @(negedge clk);
      check("mis_req", 32'(data_req), 32'd1);
      check("mis_addr", data_addr, 32'h100);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1357_2468;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      step();
      check("mis_req_cycles", 32'(req_cycles - cyc0), 32'd1);
`endif

      step();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
